// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the multiply/divide unit.
//   - funct codes of the R-type HI/LO instructions
//   - FSM state enum and decoded operation kind enum
package muldiv_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_MUL,
        OP_DIV,
        OP_MTHI,
        OP_MTLO
    } op_kind_e;

endpackage

// File: rtl/muldiv_dec.sv
// muldiv_dec: combinational funct decoder for the multiply/divide unit.
//   funct       in  6  R-type function field
//   op_kind_c   out    decoded operation kind (MFHI/MFLO and unknown -> OP_NONE)
//   is_signed_c out 1  operation treats operands as two's complement
module muldiv_dec
    import muldiv_pkg::*;
(
    input  logic [5:0] funct,
    output op_kind_e   op_kind_c,
    output logic       is_signed_c
);

    always_comb begin
        op_kind_c   = OP_NONE;
        is_signed_c = 1'b0;
        case (funct)
            FN_MULT: begin
                op_kind_c   = OP_MUL;
                is_signed_c = 1'b1;
            end
            FN_MULTU: op_kind_c = OP_MUL;
            FN_DIV: begin
                op_kind_c   = OP_DIV;
                is_signed_c = 1'b1;
            end
            FN_DIVU:          op_kind_c = OP_DIV;
            FN_MTHI:          op_kind_c = OP_MTHI;
            FN_MTLO:          op_kind_c = OP_MTLO;
            // Reads are served straight from the hi/lo ports.
            FN_MFHI, FN_MFLO: op_kind_c = OP_NONE;
            default:          op_kind_c = OP_NONE;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative HI/LO multiply/divide unit, one bit per cycle.
//   clk, reset_n      clock, synchronous active-low reset
//   start, funct      issue strobe and function field
//   a, b              rs / rt operands
//   flush             cancel the in-flight operation
//   busy              high while an operation is in CALC or FIX
//   done              one-cycle pulse after hi/lo are written by mul/div
//   hi, lo            registered HI/LO
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned PW    = 2 * WIDTH;

    op_kind_e dec_op_c;
    logic     dec_signed_c;

    muldiv_dec u_dec (
        .funct       (funct),
        .op_kind_c   (dec_op_c),
        .is_signed_c (dec_signed_c)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic accept_c;
    logic launch_c;
    logic last_iter_c;

    assign accept_c    = (state_q == S_IDLE) && start && !flush;
    assign launch_c    = accept_c && ((dec_op_c == OP_MUL) || (dec_op_c == OP_DIV));
    assign last_iter_c = (cnt_q == CNT_W'(WIDTH - 1));

    // Operand magnitudes; the iteration itself is always unsigned.
    logic [WIDTH-1:0] a_mag_c, b_mag_c;
    assign a_mag_c = (dec_signed_c && a[WIDTH-1]) ? -a : a;
    assign b_mag_c = (dec_signed_c && b[WIDTH-1]) ? -b : b;

    // acc holds {partial product, multiplier} for mul, {remainder, dividend/quotient} for div.
    logic [WIDTH-1:0] acc_hi_c, acc_lo_c;
    logic [WIDTH:0]   add_c, rem_c, diff_c;
    assign acc_hi_c = acc_q[PW-1:WIDTH];
    assign acc_lo_c = acc_q[WIDTH-1:0];
    assign add_c    = acc_lo_c[0] ? ({1'b0, acc_hi_c} + {1'b0, opd_q}) : {1'b0, acc_hi_c};
    assign rem_c    = {acc_hi_c, acc_lo_c[WIDTH-1]};
    // Borrow lands in bit WIDTH because the shifted remainder is below twice the divisor.
    assign diff_c   = rem_c - {1'b0, opd_q};

    // Sign-corrected results; a zero divisor yields an all-ones quotient and
    // the remainder path naturally reproduces the dividend.
    logic [PW-1:0]    prod_c;
    logic [WIDTH-1:0] quo_c, rem_res_c;
    assign prod_c    = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign quo_c     = (opd_q == '0) ? '1 : ((neg_a_q ^ neg_b_q) ? -acc_lo_c : acc_lo_c);
    assign rem_res_c = neg_a_q ? -acc_hi_c : acc_hi_c;

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (launch_c) state_d = S_CALC;
            S_CALC: begin
                if (flush)            state_d = S_IDLE;
                else if (last_iter_c) state_d = S_FIX;
            end
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand latch and one shift-add / restoring shift-subtract step per cycle.
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opd_d    = opd_q;
        is_div_d = is_div_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        if (launch_c) begin
            cnt_d    = '0;
            acc_d    = {{WIDTH{1'b0}}, a_mag_c};
            opd_d    = b_mag_c;
            is_div_d = (dec_op_c == OP_DIV);
            neg_a_d  = dec_signed_c && a[WIDTH-1];
            neg_b_d  = dec_signed_c && b[WIDTH-1];
        end else if ((state_q == S_CALC) && !flush) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (is_div_q) begin
                if (!diff_c[WIDTH]) acc_d = {diff_c[WIDTH-1:0], acc_lo_c[WIDTH-2:0], 1'b1};
                else                acc_d = {rem_c[WIDTH-1:0], acc_lo_c[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {add_c, acc_lo_c[WIDTH-1:1]};
            end
        end
    end

    // Output logic: busy/done and the HI/LO write ports.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = 1'b0;
        hi_d   = hi_q;
        lo_d   = lo_q;
        if ((state_q == S_FIX) && !flush) begin
            done_d = 1'b1;
            if (is_div_q) begin
                hi_d = rem_res_c;
                lo_d = quo_c;
            end else begin
                hi_d = prod_c[PW-1:WIDTH];
                lo_d = prod_c[WIDTH-1:0];
            end
        end else if (accept_c && (dec_op_c == OP_MTHI)) begin
            hi_d = a;
        end else if (accept_c && (dec_op_c == OP_MTLO)) begin
            lo_d = a;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opd_q    <= '0;
            is_div_q <= 1'b0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opd_q    <= opd_d;
            is_div_q <= is_div_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int unsigned W     = 32;
    localparam int          LIMIT = 40;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         flush;
    logic [5:0]   funct;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt, done_cnt, done_cyc;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .funct   (funct),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op in cycle 0, then watch cycles 1..LIMIT. Optional events
    // (-1 = none): re-pulse start, assert flush, or pulse reset in a given cycle.
    task automatic run_op(input logic [5:0] fn, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input int poke_cyc, input int flush_cyc, input int rst_cyc);
        busy_cnt = 0;
        done_cnt = 0;
        done_cyc = 0;
        @(negedge clk);
        start = 1'b1;
        funct = fn;
        a     = op_a;
        b     = op_b;
        flush = (flush_cyc == 0);
        for (int c = 1; c <= LIMIT; c++) begin
            @(negedge clk);
            start   = 1'b0;
            flush   = 1'b0;
            reset_n = 1'b1;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (c == poke_cyc) begin
                start = 1'b1;
                funct = FN_DIVU;
                a     = 32'd1;
                b     = 32'd1;
            end
            if (c == flush_cyc) flush = 1'b1;
            if (c == rst_cyc)   reset_n = 1'b0;
        end
    endtask

    task automatic check_op(input string tag, input int exp_busy, input int exp_done_cyc,
                            input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
        check_eq({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check_eq({tag, " done_cycle"},  64'(done_cyc), 64'(exp_done_cyc));
        check_eq({tag, " done_pulses"}, 64'(done_cnt), (exp_done_cyc != 0) ? 64'd1 : 64'd0);
        check_eq({tag, " hi"}, 64'(hi), 64'(exp_hi));
        check_eq({tag, " lo"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        funct   = '0;
        a       = '0;
        b       = '0;
        repeat (2) @(negedge clk);
        check_eq("reset busy", 64'(busy), 64'd0);
        check_eq("reset done", 64'(done), 64'd0);
        check_eq("reset hi",   64'(hi),   64'd0);
        check_eq("reset lo",   64'(lo),   64'd0);
        reset_n = 1'b1;

        run_op(FN_MULT,  32'hFFFF_FFFE, 32'd3, -1, -1, -1);
        check_op("mult -2*3", 33, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        run_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
        check_op("multu max*max", 33, 34, 32'hFFFF_FFFE, 32'h0000_0001);

        run_op(FN_DIV,   32'hFFFF_FFF9, 32'd2, -1, -1, -1);
        check_op("div -7/2", 33, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        run_op(FN_DIV,   32'd7, 32'hFFFF_FFFE, -1, -1, -1);
        check_op("div 7/-2", 33, 34, 32'h0000_0001, 32'hFFFF_FFFD);

        run_op(FN_DIVU,  32'd7, 32'd0, -1, -1, -1);
        check_op("divu 7/0", 33, 34, 32'h0000_0007, 32'hFFFF_FFFF);

        run_op(FN_DIV,   32'hFFFF_FFFB, 32'd0, -1, -1, -1);
        check_op("div -5/0", 33, 34, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

        run_op(FN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
        check_op("div minneg/-1", 33, 34, 32'h0000_0000, 32'h8000_0000);

        run_op(FN_DIVU,  32'd100, 32'd7, -1, -1, -1);
        check_op("divu 100/7", 33, 34, 32'h0000_0002, 32'h0000_000E);

        run_op(FN_MULT,  32'h8000_0000, 32'h8000_0000, -1, -1, -1);
        check_op("mult minneg^2", 33, 34, 32'h4000_0000, 32'h0000_0000);

        run_op(FN_MULT,  32'd7, 32'hFFFF_FFFF, -1, -1, -1);
        check_op("mult 7*-1", 33, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

        run_op(FN_MTHI,  32'h1234_5678, 32'd0, -1, -1, -1);
        check_op("mthi", 0, 0, 32'h1234_5678, 32'hFFFF_FFF9);

        run_op(FN_MTLO,  32'hCAFE_F00D, 32'd0, -1, -1, -1);
        check_op("mtlo", 0, 0, 32'h1234_5678, 32'hCAFE_F00D);

        run_op(FN_MULT,  32'd6, 32'd7, 5, -1, -1);
        check_op("mult restart ignored", 33, 34, 32'h0000_0000, 32'h0000_002A);

        run_op(FN_MFHI,  32'h0000_0055, 32'd9, -1, -1, -1);
        check_op("mfhi no-op", 0, 0, 32'h0000_0000, 32'h0000_002A);

        run_op(FN_MULT,  32'd3, 32'd3, -1, 0, -1);
        check_op("start+flush idle", 0, 0, 32'h0000_0000, 32'h0000_002A);

        run_op(FN_DIV,   32'd100, 32'd3, -1, 10, -1);
        check_op("div flush calc", 10, 0, 32'h0000_0000, 32'h0000_002A);

        run_op(FN_MULTU, 32'd5, 32'd5, -1, 33, -1);
        check_op("multu flush fix", 33, 0, 32'h0000_0000, 32'h0000_002A);

        run_op(FN_MULTU, 32'd5, 32'd5, -1, -1, 10);
        check_op("reset mid calc", 10, 0, 32'h0000_0000, 32'h0000_0000);

        run_op(FN_MULTU, 32'h0001_0000, 32'h0001_0000, -1, -1, -1);
        check_op("multu after reset", 33, 34, 32'h0000_0001, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/HI/LO width; legal values are even and ≥4.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  in  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  in  1  issue strobe; funct/a/b valid when high.
REQ-005 SHALL have port funct  in  6  R-type function field of the issued instruction.
REQ-006 SHALL have port a  in  WIDTH  rs operand.
REQ-007 SHALL have port b  in  WIDTH  rt operand.
REQ-008 SHALL have port flush  in  1  cancel in-flight operation.
REQ-009 SHALL have port busy  out  1  operation in progress; pipeline stalls on it.
REQ-010 SHALL have port done  out  1  one-cycle pulse; hi/lo just updated by mul/div.
REQ-011 SHALL have port hi  out  WIDTH  registered HI.
REQ-012 SHALL have port lo  out  WIDTH  registered LO.

Function
REQ-013 SHALL decode funct: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO; all other codes, including MFHI 010000 and MFLO 010010, are no-ops (reads use the hi/lo ports).
REQ-014 SHALL implement states IDLE, CALC, FIX.
REQ-015 IDLE: start with MULT/MULTU/DIV/DIVU and flush low -> latch operands (magnitudes for signed ops, signs saved), clear counter, go CALC.
REQ-016 CALC: one shift-add (mul) or restoring shift-subtract (div) iteration per cycle; after exactly WIDTH cycles go FIX.
REQ-017 FIX: apply sign correction, write hi/lo at the edge leaving FIX, go IDLE; done high in the following cycle only.
REQ-018 busy SHALL be high in CALC and FIX: WIDTH+1 cycles, starting the cycle after the accepted start; done in cycle WIDTH+2 relative to the start cycle (0).
REQ-019 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit signed/unsigned product.
REQ-020 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-021 Divide by zero: lo = all ones, hi = a; full latency, no error flag.
REQ-022 DIV most-negative / -1: lo = most-negative, hi = 0.
REQ-023 MTHI/MTLO in IDLE: hi (resp. lo) <= a at the next edge; no busy, no done.
REQ-024 start while busy SHALL be ignored; operands and state unaffected.
REQ-025 flush in CALC or FIX: return to IDLE next edge; hi/lo unchanged; no done.
REQ-026 flush and start in the same IDLE cycle: start ignored.
REQ-027 Counter SHALL be $clog2(WIDTH)+1 bits and never wrap within an operation.

Reset
REQ-028 reset_n low at an edge: state IDLE, counter 0, busy 0, done 0, hi 0, lo 0; overrides start and flush, including mid-operation.

Structure
REQ-029 Package muldiv_pkg SHALL hold the funct code constants, the state enum and the op-kind enum (MUL, DIV, MTHI, MTLO, NONE).
REQ-030 One combinational sub-module muldiv_dec (funct -> op kind, signed flag) SHALL be instantiated; datapath and FSM stay in muldiv_unit.

Verification (WIDTH=32)
REQ-031 MULT a=0xFFFFFFFE (-2), b=3 -> busy 33 cycles, done cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=7, b=0 -> lo=0xFFFFFFFF, hi=7.
REQ-034 MTHI a=0x12345678 -> hi=0x12345678 next cycle, busy never high; then MULT issued, start re-pulsed mid-CALC -> ignored, result of first op only.
REQ-035 DIV started, flush at cycle 10 -> busy low cycle 11, no done, hi/lo keep prior values.
REQ-036 reset_n low during CALC -> next cycle busy 0, hi 0, lo 0, no done.
